awid_tracker: RTL and testbench

- Write-response tracker for the AXI data-width adapter.
- Each upstream AW transaction is split into total_sub_txn downstream sub-transactions. This block records the ID and sub-transaction count at every AW handshake.
- It collects the matching downstream B responses by ID and merges them.
- When the last sub-response of a transaction arrives, it emits one merged response on rd_valid/resp for the upstream B channel.

---
 rtl/awid_tracker.sv | 135 +++++++++++++
 tb/tb_awid_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/awid_tracker.sv
// Write-response tracker for the AXI data-width adapter: records each upstream AW,
// merges the downstream sub-responses by ID and emits one merged B response per AW.
module awid_tracker #(
  parameter int AWID_WIDTH     = 3,
  parameter int BID_WIDTH      = 3,
  parameter int BRESP_WIDTH    = 2,
  parameter int RESP_ARR_WIDTH = 9,
  parameter int DEPTH          = 8
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic [AWID_WIDTH-1:0]     awid,
  input  logic [2:0]                total_sub_txn,
  input  logic                      m_aw_handshake,
  input  logic                      s_b_handshake,
  input  logic [BRESP_WIDTH-1:0]    s_bresp,
  input  logic [BID_WIDTH-1:0]      s_bid,
  output logic                      rd_valid,
  output logic [RESP_ARR_WIDTH-1:0] resp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // age is the entry's rank among valid entries: 0 = oldest, kept dense on every free
  typedef struct packed {
    logic                   valid;
    logic [AWID_WIDTH-1:0]  id;
    logic [2:0]             remaining;
    logic [3:0]             received;
    logic [BRESP_WIDTH-1:0] merged;
    logic [IDX_W-1:0]       age;
  } entry_t;

  entry_t tbl_q [DEPTH];
  entry_t tbl_d [DEPTH];

  logic                      done;
  logic [RESP_ARR_WIDTH-1:0] resp_d;
  logic                      match_found;
  logic [IDX_W-1:0]          match_idx;
  logic [IDX_W-1:0]          best_age;
  logic                      alloc_found;
  logic [IDX_W-1:0]          alloc_idx;
  logic [BRESP_WIDTH-1:0]    new_merged;
  int                        n_valid;

  // Severity order DECERR > SLVERR > OKAY > EXOKAY, as a comparable rank.
  function automatic logic [1:0] severity(input logic [BRESP_WIDTH-1:0] code);
    case (code)
      BRESP_WIDTH'(3): severity = 2'd3;
      BRESP_WIDTH'(2): severity = 2'd2;
      BRESP_WIDTH'(0): severity = 2'd1;
      default:         severity = 2'd0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    tbl_d       = tbl_q;
    done        = 1'b0;
    resp_d      = resp;
    match_found = 1'b0;
    match_idx   = '0;
    best_age    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    new_merged  = '0;
    n_valid     = 0;

    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_q[i].valid) n_valid++;
      if (!tbl_q[i].valid && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (tbl_q[i].valid && tbl_q[i].id == s_bid &&
          (!match_found || tbl_q[i].age < best_age)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
        best_age    = tbl_q[i].age;
      end
    end

    // Only entries valid before this edge can match, so a same-edge AW is never hit.
    if (s_b_handshake && match_found) begin
      if (tbl_q[match_idx].received == 4'd0 ||
          severity(s_bresp) > severity(tbl_q[match_idx].merged))
        new_merged = s_bresp;
      else
        new_merged = tbl_q[match_idx].merged;

      tbl_d[match_idx].received  = tbl_q[match_idx].received + 4'd1;
      tbl_d[match_idx].remaining = tbl_q[match_idx].remaining - 3'd1;
      tbl_d[match_idx].merged    = new_merged;

      if (tbl_q[match_idx].remaining == 3'd1) begin
        done                    = 1'b1;
        tbl_d[match_idx].valid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (tbl_q[i].valid && tbl_q[i].age > best_age)
            tbl_d[i].age = tbl_q[i].age - 1'b1;
        end
        resp_d = '0;
        resp_d[BRESP_WIDTH-1:0]                  = new_merged;
        resp_d[BRESP_WIDTH +: AWID_WIDTH]        = tbl_q[match_idx].id;
        resp_d[BRESP_WIDTH + AWID_WIDTH +: 4]    = tbl_q[match_idx].received + 4'd1;
      end
    end

    // A slot freed on this edge is not visible to alloc_idx until the next edge.
    if (m_aw_handshake && total_sub_txn != 3'd0 && alloc_found) begin
      tbl_d[alloc_idx].valid     = 1'b1;
      tbl_d[alloc_idx].id        = awid;
      tbl_d[alloc_idx].remaining = total_sub_txn;
      tbl_d[alloc_idx].received  = 4'd0;
      tbl_d[alloc_idx].merged    = BRESP_WIDTH'(1);
      tbl_d[alloc_idx].age       = IDX_W'(n_valid - (done ? 1 : 0));
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      // NOTE: every field of the table is reset, not just valid, so no X reaches resp.
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      rd_valid <= 1'b0;
      resp     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
      rd_valid <= done;
      resp     <= resp_d;
    end
  end

endmodule

// File: tb/tb_awid_tracker.sv
// Directed self-checking bench for awid_tracker: each step pushes its expected
// outcome to a scoreboard queue, which is popped and compared after the edge.
module tb_awid_tracker;

  logic       aclk = 1'b0;
  logic       arst_n;
  logic [2:0] awid;
  logic [2:0] total_sub_txn;
  logic       m_aw_handshake;
  logic       s_b_handshake;
  logic [1:0] s_bresp;
  logic [2:0] s_bid;
  logic       rd_valid;
  logic [8:0] resp;

  typedef struct {
    logic       v;
    logic [8:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  awid_tracker dut (
    .aclk           (aclk),
    .arst_n         (arst_n),
    .awid           (awid),
    .total_sub_txn  (total_sub_txn),
    .m_aw_handshake (m_aw_handshake),
    .s_b_handshake  (s_b_handshake),
    .s_bresp        (s_bresp),
    .s_bid          (s_bid),
    .rd_valid       (rd_valid),
    .resp           (resp)
  );

  always #5 aclk = ~aclk;

  function automatic logic [8:0] mk(input logic [3:0] cnt, input logic [2:0] id,
                                    input logic [1:0] br);
    return {cnt, id, br};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the queued expectation.
  task automatic step(input logic aw, input logic [2:0] id, input logic [2:0] tot,
                      input logic b, input logic [2:0] bid, input logic [1:0] br,
                      input logic ev, input logic [8:0] er, input string tag);
    exp_t e;
    exp_q.push_back('{v: ev, r: er});
    m_aw_handshake = aw;
    awid           = id;
    total_sub_txn  = tot;
    s_b_handshake  = b;
    s_bid          = bid;
    s_bresp        = br;
    @(posedge aclk);
    #1;
    e = exp_q.pop_front();
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(e.v));
    if (e.v) check({tag, " resp"}, 32'(resp), 32'(e.r));
  endtask

  task automatic aw(input logic [2:0] id, input logic [2:0] tot, input string tag);
    step(1'b1, id, tot, 1'b0, 3'd0, 2'd0, 1'b0, 9'd0, tag);
  endtask

  task automatic b(input logic [2:0] bid, input logic [1:0] br, input logic ev,
                   input logic [8:0] er, input string tag);
    step(1'b0, 3'd0, 3'd0, 1'b1, bid, br, ev, er, tag);
  endtask

  initial begin
    arst_n = 1'b0;
    m_aw_handshake = 1'b0; s_b_handshake = 1'b0;
    awid = '0; total_sub_txn = '0; s_bid = '0; s_bresp = '0;

    // Reset held for two edges with random traffic
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
           2'($urandom), 1'b0, 9'd0, "reset");
    check("reset resp", 32'(resp), 32'd0);
    arst_n = 1'b1;
    b(3'd3, 2'd0, 1'b0, 9'd0, "empty b");

    // Same-ID ordering
    aw(3'd1, 3'd3, "aw1a"); aw(3'd2, 3'd2, "aw2a"); aw(3'd3, 3'd4, "aw3");
    aw(3'd1, 3'd5, "aw1b"); aw(3'd2, 3'd2, "aw2b");
    b(3'd1, 2'd0, 1'b0, 9'd0, "b1 #1");
    b(3'd1, 2'd2, 1'b0, 9'd0, "b1 #2");
    b(3'd1, 2'd0, 1'b1, 9'b0011_001_10, "b1 #3");
    b(3'd1, 2'd0, 1'b0, 9'd0, "b1 #4");
    b(3'd1, 2'd2, 1'b0, 9'd0, "b1 #5");
    b(3'd1, 2'd0, 1'b0, 9'd0, "b1 #6");

    // Completion of the remaining entries
    b(3'd1, 2'd0, 1'b0, 9'd0, "b1 #7");
    b(3'd1, 2'd0, 1'b1, mk(4'd5, 3'd1, 2'd2), "b1 #8");
    b(3'd2, 2'd0, 1'b0, 9'd0, "b2 #1");
    b(3'd2, 2'd0, 1'b1, mk(4'd2, 3'd2, 2'd0), "b2 #2");
    b(3'd3, 2'd3, 1'b0, 9'd0, "b3 #1");
    b(3'd3, 2'd0, 1'b0, 9'd0, "b3 #2");
    b(3'd3, 2'd0, 1'b0, 9'd0, "b3 #3");
    b(3'd3, 2'd0, 1'b1, mk(4'd4, 3'd3, 2'd3), "b3 #4");
    step(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 9'd0, "idle");
    check("resp hold", 32'(resp), 32'(mk(4'd4, 3'd3, 2'd3)));

    // Reset mid-operation: the second id2 entry needs one more response
    b(3'd2, 2'd0, 1'b0, 9'd0, "b2 #3");
    arst_n = 1'b0;
    b(3'd2, 2'd0, 1'b0, 9'd0, "b2 in reset");
    arst_n = 1'b1;
    check("mid reset resp", 32'(resp), 32'd0);
    b(3'd2, 2'd0, 1'b0, 9'd0, "b2 discarded");

    // Interleaved IDs
    aw(3'd2, 3'd2, "il aw2"); aw(3'd3, 3'd1, "il aw3");
    b(3'd3, 2'd0, 1'b1, mk(4'd1, 3'd3, 2'd0), "il b3");
    b(3'd2, 2'd1, 1'b0, 9'd0, "il b2 #1");
    b(3'd2, 2'd1, 1'b1, mk(4'd2, 3'd2, 2'd1), "il b2 #2");

    // Single sub-transaction with same-edge B, then zero-count AW ignored
    step(1'b1, 3'd5, 3'd1, 1'b1, 3'd5, 2'd2, 1'b0, 9'd0, "same edge");
    b(3'd5, 2'd2, 1'b1, mk(4'd1, 3'd5, 2'd2), "single b5");
    aw(3'd6, 3'd0, "aw zero");
    b(3'd6, 2'd0, 1'b0, 9'd0, "b6 none");

    // Full table, dropped 9th AW, freed slot only reusable on the next edge
    aw(3'd4, 3'd1, "full 0"); aw(3'd0, 3'd1, "full 1"); aw(3'd4, 3'd2, "full 2");
    aw(3'd1, 3'd1, "full 3"); aw(3'd2, 3'd1, "full 4"); aw(3'd3, 3'd1, "full 5");
    aw(3'd5, 3'd1, "full 6"); aw(3'd6, 3'd1, "full 7");
    aw(3'd4, 3'd1, "full drop");
    b(3'd4, 2'd0, 1'b1, mk(4'd1, 3'd4, 2'd0), "full b4 #1");
    b(3'd4, 2'd2, 1'b0, 9'd0, "full b4 #2");
    b(3'd4, 2'd0, 1'b1, mk(4'd2, 3'd4, 2'd2), "full b4 #3");
    b(3'd4, 2'd0, 1'b0, 9'd0, "full b4 #4");
    // Two slots now free; fill one, then AW on the same edge as a free is dropped
    aw(3'd7, 3'd2, "refill");
    aw(3'd0, 3'd1, "fill last");
    step(1'b1, 3'd7, 3'd1, 1'b1, 3'd0, 2'd0, 1'b1, mk(4'd1, 3'd0, 2'd0), "free+aw");
    b(3'd7, 2'd3, 1'b0, 9'd0, "b7 #1");
    b(3'd7, 2'd0, 1'b1, mk(4'd2, 3'd7, 2'd3), "b7 #2");
    b(3'd7, 2'd0, 1'b0, 9'd0, "b7 dropped");
    aw(3'd7, 3'd1, "reuse aw7");
    b(3'd7, 2'd3, 1'b1, mk(4'd1, 3'd7, 2'd3), "reuse b7");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
